// File: rtl/fixed_pkg.sv
// Shared definitions for the binary32 -> fixed-point converter.
// Holds the binary32 field widths, the exponent bias, the result flag bit
// indices and the per-beat round-mode encoding carried on s_axis_a_tuser.
package fixed_pkg;

  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MANT_W   = 23;
  localparam int unsigned EXP_BIAS = 127;

  // Result flag bits on m_axis_result_tuser
  localparam int unsigned FLAG_W   = 2;
  localparam int unsigned FLAG_OVF = 0;
  localparam int unsigned FLAG_NAN = 1;

  typedef enum logic {
    RND_RNE = 1'b0,  // round to nearest, ties to even
    RND_RTZ = 1'b1   // truncate toward zero
  } round_mode_e;

endpackage

// File: rtl/pipe_stage_ctrl.sv
// Valid/advance control for one bubble-collapsing pipeline stage.
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   up_valid    - the upstream stage (or input port) holds a beat
//   down_ready  - the downstream stage (or output port) accepts this edge
//   valid       - this stage holds a beat
//   ready       - this stage accepts a new beat this edge; also the load
//                 enable for the stage's datapath registers
module pipe_stage_ctrl (
  input  logic clk,
  input  logic rst,
  input  logic up_valid,
  input  logic down_ready,
  output logic valid,
  output logic ready
);

  // A stage may load when empty or when its current beat is leaving.
  assign ready = !valid || down_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (ready) begin
      valid <= up_valid;
    end
  end

endmodule

// File: rtl/fp32_to_fixed_pipe.sv
// IEEE-754 binary32 to signed fixed-point converter, 3-stage pipeline.
//   S1: unpack fields, classify (zero/denormal, inf, NaN), compute the
//       net binary shift for the integer significand.
//   S2: align-shift and round the magnitude (RNE or RTZ per beat).
//   S3: negate, saturate and produce flags.
// Ports:
//   aclk, areset           - clock, synchronous active-high reset
//   s_axis_a_*             - input stream: tdata binary32, tuser round mode
//   m_axis_result_*        - output stream: tdata fixed-point result,
//                            tuser flags {nan, overflow}
// Only the stage valid bits are reset; datapath registers are don't-care
// while their valid bit is low.
module fp32_to_fixed_pipe
  import fixed_pkg::*;
#(
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned FRAC_BITS = 16
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [31:0]          s_axis_a_tdata,
  input  logic                 s_axis_a_tuser,
  input  logic                 s_axis_a_tvalid,
  output logic                 s_axis_a_tready,
  output logic [OUT_WIDTH-1:0] m_axis_result_tdata,
  output logic [FLAG_W-1:0]    m_axis_result_tuser,
  output logic                 m_axis_result_tvalid,
  input  logic                 m_axis_result_tready
);

  localparam int unsigned SHW  = 10;                 // signed shift width
  localparam int unsigned MW   = MANT_W + 1;         // significand with hidden bit
  localparam int unsigned MAGW = OUT_WIDTH + 1;      // magnitude up to 2^OUT_WIDTH
  localparam int unsigned WIDE = OUT_WIDTH + MW + 1; // pre-saturation working width
  localparam logic [OUT_WIDTH-1:0] MAX_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MIN_NEG = ~MAX_POS;

  // ---------------- stage control ----------------
  logic v1, v2, v3, r1, r2, r3;

  pipe_stage_ctrl u_ctrl1 (.clk(aclk), .rst(areset), .up_valid(s_axis_a_tvalid),
                           .down_ready(r2), .valid(v1), .ready(r1));
  pipe_stage_ctrl u_ctrl2 (.clk(aclk), .rst(areset), .up_valid(v1),
                           .down_ready(r3), .valid(v2), .ready(r2));
  pipe_stage_ctrl u_ctrl3 (.clk(aclk), .rst(areset), .up_valid(v2),
                           .down_ready(m_axis_result_tready), .valid(v3), .ready(r3));

  assign s_axis_a_tready      = r1;
  assign m_axis_result_tvalid = v3;

  // ---------------- S1: unpack / classify ----------------
  logic [EXP_W-1:0]  in_exp;
  logic [MANT_W-1:0] in_frac;
  logic [SHW-1:0]    sh_c;

  assign in_exp  = s_axis_a_tdata[30:23];
  assign in_frac = s_axis_a_tdata[22:0];
  // value * 2^FRAC_BITS = mant24 * 2^(exp - bias - 23 + FRAC_BITS), two's complement
  assign sh_c = SHW'(in_exp) + SHW'(FRAC_BITS) - SHW'(EXP_BIAS + MANT_W);

  logic              s1_sign, s1_zero, s1_inf, s1_nan;
  round_mode_e       s1_mode;
  logic [MW-1:0]     s1_mant;
  logic [SHW-1:0]    s1_sh;

  always_ff @(posedge aclk) begin
    if (r1) begin
      s1_sign <= s_axis_a_tdata[31];
      s1_zero <= (in_exp == '0);
      s1_inf  <= (in_exp == '1) && (in_frac == '0);
      s1_nan  <= (in_exp == '1) && (in_frac != '0);
      s1_mode <= round_mode_e'(s_axis_a_tuser);
      s1_mant <= {1'b1, in_frac};
      s1_sh   <= sh_c;
    end
  end

  // ---------------- S2: align and round magnitude ----------------
  logic [SHW-1:0]  rs;
  logic [2*MW-1:0] ext;
  logic [MW-1:0]   int_part;
  logic            guard, sticky, round_up, big_shift;
  logic [WIDE-1:0] wide;
  logic [MAGW-1:0] mag_c;
  logic            huge_c;

  always_comb begin
    rs        = '0 - s1_sh;
    ext       = '0;
    int_part  = '0;
    guard     = 1'b0;
    sticky    = 1'b0;
    round_up  = 1'b0;
    big_shift = 1'b0;
    wide      = '0;
    if (s1_sh[SHW-1]) begin
      // Right shift: a shift of MW+1 or more leaves a value below 0.5,
      // which rounds to zero in either mode.
      if (rs <= SHW'(MW)) begin
        ext      = {s1_mant, {MW{1'b0}}} >> rs;
        int_part = ext[2*MW-1:MW];
        guard    = ext[MW-1];
        sticky   = |ext[MW-2:0];
        round_up = (s1_mode == RND_RNE) && guard && (sticky || int_part[0]);
        wide     = WIDE'(int_part) + WIDE'(round_up);
      end
    end else if (s1_sh >= SHW'(OUT_WIDTH)) begin
      // Hidden bit alone would land at or above 2^OUT_WIDTH
      big_shift = 1'b1;
    end else begin
      wide = WIDE'(s1_mant) << s1_sh;
    end
    mag_c  = wide[MAGW-1:0];
    huge_c = big_shift || (|wide[WIDE-1:MAGW]);
  end

  logic            s2_sign, s2_zero, s2_inf, s2_nan, s2_huge;
  logic [MAGW-1:0] s2_mag;

  always_ff @(posedge aclk) begin
    if (r2) begin
      s2_sign <= s1_sign;
      s2_zero <= s1_zero;
      s2_inf  <= s1_inf;
      s2_nan  <= s1_nan;
      s2_huge <= huge_c;
      s2_mag  <= mag_c;
    end
  end

  // ---------------- S3: negate, saturate, flag ----------------
  logic [MAGW-1:0]      lim;
  logic                 ovf;
  logic [OUT_WIDTH-1:0] mag_w, data_c;
  logic [FLAG_W-1:0]    flags_c;

  always_comb begin
    // Negative side reaches one further: -2^(OUT_WIDTH-1) is representable.
    lim     = MAGW'(MAX_POS) + MAGW'(s2_sign);
    ovf     = s2_inf || s2_huge || (s2_mag > lim);
    mag_w   = s2_mag[OUT_WIDTH-1:0];
    data_c  = '0;
    flags_c = '0;
    if (s2_nan) begin
      flags_c[FLAG_NAN] = 1'b1;
    end else if (s2_zero) begin
      data_c = '0;
    end else if (ovf) begin
      data_c            = s2_sign ? MIN_NEG : MAX_POS;
      flags_c[FLAG_OVF] = 1'b1;
    end else begin
      data_c = s2_sign ? ('0 - mag_w) : mag_w;
    end
  end

  logic [OUT_WIDTH-1:0] s3_data;
  logic [FLAG_W-1:0]    s3_flags;

  always_ff @(posedge aclk) begin
    if (r3) begin
      s3_data  <= data_c;
      s3_flags <= flags_c;
    end
  end

  assign m_axis_result_tdata = s3_data;
  assign m_axis_result_tuser = s3_flags;

endmodule

// File: tb/tb_fp32_to_fixed_pipe.sv
// Scoreboard bench for fp32_to_fixed_pipe (OUT_WIDTH=32, FRAC_BITS=16).
// Driver pushes expected results on acceptance; a separate monitor pops
// and compares on every output transfer and checks stall stability.
module tb_fp32_to_fixed_pipe;

  localparam int unsigned OW = 32;
  localparam int unsigned FB = 16;

  logic          aclk = 1'b0;
  logic          areset;
  logic [31:0]   s_tdata;
  logic          s_tuser;
  logic          s_tvalid;
  logic          s_tready;
  logic [OW-1:0] m_tdata;
  logic [1:0]    m_tuser;
  logic          m_tvalid;
  logic          m_tready;

  fp32_to_fixed_pipe #(.OUT_WIDTH(OW), .FRAC_BITS(FB)) dut (
    .aclk                 (aclk),
    .areset               (areset),
    .s_axis_a_tdata       (s_tdata),
    .s_axis_a_tuser       (s_tuser),
    .s_axis_a_tvalid      (s_tvalid),
    .s_axis_a_tready      (s_tready),
    .m_axis_result_tdata  (m_tdata),
    .m_axis_result_tuser  (m_tuser),
    .m_axis_result_tvalid (m_tvalid),
    .m_axis_result_tready (m_tready)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    logic [OW-1:0] data;
    logic [1:0]    flags;
    int            acc;
    bit            chk_lat;
    logic [31:0]   src;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rdy_mode = 2;  // 0 random, 1 high, 2 low

  // Reference: exact rational scaling of the binary32 value.
  function automatic void ref_model(input logic [31:0] x, input logic rtz,
                                    output logic [OW-1:0] d, output logic [1:0] f);
    int          e, k, n;
    longint      m, q, rem, den;
    logic [127:0] mag, lim;
    bit          s, big;
    s   = x[31];
    e   = int'(x[30:23]);
    m   = longint'({1'b1, x[22:0]});
    d   = '0;
    f   = 2'b00;
    big = 1'b0;
    mag = '0;
    if (e == 0) return;
    if (e == 255) begin
      if (x[22:0] != 0) begin f = 2'b10; return; end
      big = 1'b1;
    end else begin
      k = e - 127 - 23 + int'(FB);
      if (k >= 0) begin
        if (k > 90) big = 1'b1;
        else mag = 128'(m) << k;
      end else begin
        n = -k;
        if (n <= 60) begin
          den = longint'(1) << n;
          q   = m / den;
          rem = m - q * den;
          if (!rtz && ((2 * rem > den) || (2 * rem == den && q[0]))) q = q + 1;
          mag = 128'(q);
        end
      end
    end
    lim = (128'(1) << (OW - 1)) - 128'(1) + 128'(s);
    if (big || mag > lim) begin
      f = 2'b01;
      d = s ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end else begin
      d = s ? OW'(128'(0) - mag) : mag[OW-1:0];
    end
  endfunction

  // Drive one beat; returns the negedge cycle stamp of the accepting edge.
  task automatic send(input logic [31:0] x, input logic rtz, input bit chk,
                      input bit use_model, input logic [OW-1:0] xd,
                      input logic [1:0] xf, output int acc);
    exp_t ent;
    bit   ok;
    int   waited;
    s_tdata  = x;
    s_tuser  = rtz;
    s_tvalid = 1'b1;
    ok       = 1'b0;
    waited   = 0;
    acc      = 0;
    while (!ok) begin
      @(negedge aclk);
      ok  = s_tready;
      acc = cyc;
      @(posedge aclk);
      waited++;
      if (!ok && waited > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: tready=%0b after %0d cycles, required 1", s_tready, waited);
        break;
      end
    end
    if (ok) begin
      ent.src = x; ent.acc = acc; ent.chk_lat = chk;
      if (use_model) ref_model(x, rtz, ent.data, ent.flags);
      else begin ent.data = xd; ent.flags = xf; end
      sb.push_back(ent);
    end
    #1;
    s_tvalid = 1'b0;
  endtask

  // m_axis_result_tready driver
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        0:       m_tready = 1'($urandom_range(0, 1));
        1:       m_tready = 1'b1;
        default: m_tready = 1'b0;
      endcase
    end
  end

  // Monitor
  bit            stalled = 1'b0;
  logic [OW-1:0] held_d;
  logic [1:0]    held_f;
  initial begin
    exp_t e;
    forever begin
      @(negedge aclk);
      if (!areset && m_tvalid) begin
        if (stalled) begin
          n_cmp++;
          if (m_tdata !== held_d || m_tuser !== held_f) begin
            n_bad++;
            $display("FAIL stall_hold: got %h/%b, held %h/%b", m_tdata, m_tuser, held_d, held_f);
          end
        end
        if (m_tready) begin
          stalled = 1'b0;
          n_cmp++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_beat: got %h/%b, required no beat", m_tdata, m_tuser);
          end else begin
            e = sb.pop_front();
            if (m_tdata !== e.data || m_tuser !== e.flags) begin
              n_bad++;
              $display("FAIL result(%h): got %h flags %b, required %h flags %b",
                       e.src, m_tdata, m_tuser, e.data, e.flags);
            end
            if (e.chk_lat) begin
              n_cmp++;
              if (cyc - e.acc != 3) begin
                n_bad++;
                $display("FAIL latency(%h): got %0d, required 3", e.src, cyc - e.acc);
              end
            end
          end
        end else begin
          stalled = 1'b1;
          held_d  = m_tdata;
          held_f  = m_tuser;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic check_bit(input string name, input logic got, input logic req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b", name, got, req);
    end
  endtask

  typedef struct { logic [31:0] x; logic rtz; logic [31:0] d; logic [1:0] f; } vec_t;
  vec_t vecs[$] = '{
    '{32'h3FC00000, 1'b0, 32'h00018000, 2'b00},
    '{32'hC0100000, 1'b0, 32'hFFFDC000, 2'b00},
    '{32'h37C00000, 1'b0, 32'h00000002, 2'b00},
    '{32'h37C00000, 1'b1, 32'h00000001, 2'b00},
    '{32'h37000000, 1'b0, 32'h00000000, 2'b00},
    '{32'h7F800000, 1'b0, 32'h7FFFFFFF, 2'b01},
    '{32'hFF800000, 1'b0, 32'h80000000, 2'b01},
    '{32'h47800000, 1'b0, 32'h7FFFFFFF, 2'b01},
    '{32'hC7000000, 1'b0, 32'h80000000, 2'b00},
    '{32'h47000000, 1'b0, 32'h7FFFFFFF, 2'b01},
    '{32'h7FC00000, 1'b0, 32'h00000000, 2'b10},
    '{32'h80000000, 1'b0, 32'h00000000, 2'b00},
    '{32'h00400000, 1'b0, 32'h00000000, 2'b00},
    '{32'h4E800000, 1'b1, 32'h7FFFFFFF, 2'b01}
  };

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    int unsigned sel;
    sel = $urandom_range(0, 19);
    if (sel == 0)      e = 8'd0;
    else if (sel == 1) e = 8'd255;
    else               e = 8'($urandom_range(100, 160));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  initial begin
    int acc, first_acc, last_acc;
    areset   = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tuser  = 1'b0;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    check_bit("reset_tvalid", m_tvalid, 1'b0);
    check_bit("reset_tready", s_tready, 1'b1);
    @(posedge aclk); #1;

    // Directed vectors, back-to-back, tready high, latency checked
    rdy_mode = 1;
    @(posedge aclk); #1;
    foreach (vecs[i]) send(vecs[i].x, vecs[i].rtz, 1'b1, 1'b0, vecs[i].d, vecs[i].f, acc);
    repeat (6) @(posedge aclk); #1;

    // Throughput: 20 random beats back-to-back must take 20 consecutive edges
    for (int i = 0; i < 20; i++) begin
      send(rand_fp(), 1'($urandom_range(0, 1)), 1'b1, 1'b1, '0, '0, acc);
      if (i == 0) first_acc = acc;
      last_acc = acc;
    end
    n_cmp++;
    if (last_acc - first_acc != 19) begin
      n_bad++;
      $display("FAIL throughput: 20 beats over %0d cycles, required 19", last_acc - first_acc);
    end
    repeat (6) @(posedge aclk); #1;

    // Random traffic with gaps and 50% output backpressure
    rdy_mode = 0;
    for (int i = 0; i < 100; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge aclk);
      #1;
      send(rand_fp(), 1'($urandom_range(0, 1)), 1'b0, 1'b1, '0, '0, acc);
    end
    rdy_mode = 1;
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge aclk);
    #1;

    // Reset with a full pipeline stalled at the output
    rdy_mode = 2;
    @(posedge aclk); #1;
    for (int i = 0; i < 3; i++) send(rand_fp(), 1'b0, 1'b0, 1'b1, '0, '0, acc);
    @(negedge aclk);
    check_bit("full_tvalid", m_tvalid, 1'b1);
    @(posedge aclk); #1;
    areset = 1'b1;
    sb.delete();
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    check_bit("post_reset_tvalid", m_tvalid, 1'b0);
    check_bit("post_reset_tready", s_tready, 1'b1);
    @(posedge aclk); #1;
    rdy_mode = 1;
    repeat (8) @(posedge aclk); #1;  // any stale beat would surface here as unexpected
    send(32'hC0100000, 1'b0, 1'b1, 1'b0, 32'hFFFDC000, 2'b00, acc);

    // Drain
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge aclk);
    @(negedge aclk);
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d beats outstanding, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
